// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding, entry layout and default sizes for the datapath trace buffer.
package trace_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARMED = 2'd1,
    CAPTURE = 2'd2,
    DONE = 2'd3
  } trace_state_t;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] pc_q;
    logic [DEF_DATA_W-1:0] pc_d;
    logic [DEF_DATA_W-1:0] instruction;
    logic reg_write_en;
  } trace_entry_t;
endpackage

// File: rtl/trace_ring.sv
// trace_ring: circular entry store; a write into a full ring overwrites the oldest entry.
module trace_ring #(
  parameter int DEPTH = 8,
  parameter int W = 97
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clock)
    if (wr) mem[wp] <= wdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (wr) begin
      wp <= wp + 1'b1;
      if (full) rp <= rp + 1'b1;
      else count <= count + 1'b1;
    end else if (rd && !empty) begin
      rp <= rp + 1'b1;
      count <= count - 1'b1;
    end
endmodule

// File: rtl/datapath_trace_buffer.sv
// datapath_trace_buffer: captures per-cycle DataPath state into a ring, halts after a limit, drains oldest-first.
// Optional trigger-PC start condition enabled by TRACE_TRIGGER_EN.
module datapath_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   pc_q,
  input  logic [DATA_W-1:0]   pc_d,
  input  logic [DATA_W-1:0]   instruction,
  input  logic                reg_write_en,
  input  logic                arm,
  input  logic [CNT_W-1:0]    stop_limit,
  input  logic [DATA_W-1:0]   trig_pc,
  output logic                halt,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                overflow,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [3*DATA_W:0]   rd_data,
  output logic [1:0]          state
);
  localparam int EW = 3*DATA_W + 1;
  trace_state_t cur, nxt;
  logic [CNT_W-1:0] limit, cnt_inc;
  logic trig_hit, cap, pop, full, empty;
  logic [EW-1:0] head;
`ifdef TRACE_TRIGGER_EN
  logic [DATA_W-1:0] trig;
  always_ff @(posedge clock or posedge reset)
    if (reset) trig <= '0;
    else if (arm) trig <= trig_pc;
  assign trig_hit = pc_q == trig;
`else
  logic unused_trig;
  assign unused_trig = ^trig_pc;
  assign trig_hit = 1'b1;
`endif
  assign cnt_inc = &cycle_count ? cycle_count : cycle_count + 1'b1;
  assign cap = !arm && (cur == CAPTURE || (cur == ARMED && trig_hit));
  assign pop = !arm && cur == DONE && !empty && rd_ready;
  always_comb begin
    nxt = cur;
    nxt = arm ? ARMED : cap ? (cnt_inc == limit ? DONE : CAPTURE) : cur;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cur <= IDLE;
      limit <= CNT_W'(1);
      cycle_count <= '0;
      overflow <= 1'b0;
    end else begin
      cur <= nxt;
      if (arm) begin
        limit <= stop_limit == '0 ? CNT_W'(1) : stop_limit;
        cycle_count <= '0;
        overflow <= 1'b0;
      end else if (cap) begin
        cycle_count <= cnt_inc;
        if (full) overflow <= 1'b1;
      end
    end
  trace_ring #(.DEPTH(DEPTH), .W(EW)) ring (
    .clock (clock),
    .reset (reset),
    .clr   (arm),
    .wr    (cap),
    .rd    (pop),
    .wdata ({pc_q, pc_d, instruction, reg_write_en}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  assign halt = cur == DONE;
  assign rd_valid = halt && !empty;
  assign rd_data = rd_valid ? head : '0;
  assign state = cur;
endmodule

// File: tb/tb_datapath_trace_buffer.sv
// tb_datapath_trace_buffer: randomized runs checked against a queue-based reference model.
module tb_datapath_trace_buffer;
  import trace_pkg::*;
  localparam int DW = 32;
  localparam int DEP = 8;
  localparam int CW = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] pc_q = '0, pc_d = '0, instruction = '0, trig_pc = '0;
  logic reg_write_en = 1'b0, arm = 1'b0, rd_ready = 1'b0;
  logic [CW-1:0] stop_limit = '0;
  logic halt, overflow, rd_valid;
  logic [CW-1:0] cycle_count;
  logic [3*DW:0] rd_data;
  logic [1:0] state;
  datapath_trace_buffer #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_q         (pc_q),
    .pc_d         (pc_d),
    .instruction  (instruction),
    .reg_write_en (reg_write_en),
    .arm          (arm),
    .stop_limit   (stop_limit),
    .trig_pc      (trig_pc),
    .halt         (halt),
    .cycle_count  (cycle_count),
    .overflow     (overflow),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .state        (state)
  );
  always #5 clock = ~clock;
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference model: mode 0 idle, 1 waiting for trigger, 2 capturing, 3 done/draining.
  int m_mode = 0;
  int m_cyc = 0;
  int m_lim = 1;
  bit m_ovf = 1'b0;
  logic [DW-1:0] m_trig = '0;
  logic [3*DW:0] q[$];
  task automatic m_capture();
    trace_entry_t e;
    e = '{pc_q: pc_q, pc_d: pc_d, instruction: instruction, reg_write_en: reg_write_en};
    q.push_back(e);
    if (q.size() > DEP) begin
      void'(q.pop_front());
      m_ovf = 1'b1;
    end
    if (m_cyc < 65535) m_cyc++;
    m_mode = (m_cyc == m_lim) ? 3 : 2;
  endtask
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0;
      m_cyc = 0;
      m_ovf = 1'b0;
      q.delete();
    end else if (arm) begin
      q.delete();
      m_cyc = 0;
      m_ovf = 1'b0;
      m_lim = (stop_limit == 0) ? 1 : int'(stop_limit);
      m_trig = trig_pc;
      m_mode = 1;
    end else if (m_mode == 1) begin
`ifdef TRACE_TRIGGER_EN
      if (pc_q == m_trig) m_capture();
`else
      m_capture();
`endif
    end else if (m_mode == 2) m_capture();
    else if (m_mode == 3 && q.size() > 0 && rd_ready) void'(q.pop_front());
  end
  task automatic check_all();
    bit v;
    v = (m_mode == 3) && (q.size() > 0);
    check("state", 128'(state), 128'(m_mode));
    check("halt", 128'(halt), 128'(m_mode == 3));
    check("cycle_count", 128'(cycle_count), 128'(m_cyc));
    check("overflow", 128'(overflow), 128'(m_ovf));
    check("rd_valid", 128'(rd_valid), 128'(v));
    check("rd_data", 128'(rd_data), v ? 128'(q[0]) : 128'(0));
  endtask
  initial begin
    logic [DW-1:0] pc;
    bit did_async;
    pc = '0;
    did_async = 1'b0;
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      check_all();
      if (!did_async && m_mode == 3 && cyc > 1000) begin
        #2 reset = 1'b1;
        #1 check_all();
        check("async_halt", 128'(halt), 128'(0));
        check("async_state", 128'(state), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        did_async = 1'b1;
      end
      pc = (pc + 32'd4) & 32'h3c;
      pc_q = pc;
      pc_d = pc + 32'd4;
      instruction = $urandom;
      reg_write_en = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      stop_limit = CW'($urandom_range(0, 20));
      trig_pc = DW'($urandom_range(0, 15) * 4);
      arm = (m_mode == 0) || (m_mode == 3 && q.size() == 0 && $urandom_range(0, 3) == 0)
            || ($urandom_range(0, 99) == 0);
    end
    if (!did_async) check("async_reached", 128'(did_async), 128'(1));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/datapath_trace_buffer.md
Name: datapath_trace_buffer

Overview:
- Synthesizable successor to the cycle-display-and-stop testbench of the single-cycle DataPath.
- Records per-cycle datapath state (pcQ, pcD, instruction, regWriteEnable) into a circular buffer for a run of cycles.
- Asserts a halt flag after a programmable number of captured cycles, then lets the capture be drained oldest-first over a valid/ready port.
- Sits beside DataPath, fed from its debug taps.

Parameters:
- DATA_W, 32, width of pc_q, pc_d and instruction.
- DEPTH, 8, trace entries; power of two, at least 2.
- CNT_W, 16, width of cycle counter and stop limit.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_q  input  DATA_W  current PC (register Q).
- pc_d  input  DATA_W  next PC (register D).
- instruction  input  DATA_W  fetched instruction.
- reg_write_en  input  1  register-file write enable.
- arm  input  1  one-cycle pulse; clears the buffer and starts a new run.
- stop_limit  input  CNT_W  captured cycles before halt; sampled on arm. A value of 0 is treated as 1.
- trig_pc  input  DATA_W  trigger PC; sampled on arm. Used only with TRACE_TRIGGER_EN.
- halt  output  1  high in DONE.
- cycle_count  output  CNT_W  cycles captured this run.
- overflow  output  1  at least one entry was overwritten this run.
- rd_valid  output  1  oldest unread entry available.
- rd_ready  input  1  consumer accepts entry.
- rd_data  output  3*DATA_W+1  packed as {pc_q, pc_d, instruction, reg_write_en}.
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset values: state=IDLE, all pointers and the entry count 0, cycle_count=0, halt=0, overflow=0, rd_valid=0, rd_data=0.
- FSM encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE: on arm -> ARMED.
- ARMED: goes to CAPTURE on the cycle the trigger condition holds. With TRACE_TRIGGER_EN the condition is pc_q==trig_pc; without it, the condition is always true, so ARMED lasts one cycle. The triggering cycle's sample is captured in the same edge as the transition.
- CAPTURE: every rising edge writes the current inputs at the write pointer.
  - Write pointer increments modulo DEPTH.
  - Entry count saturates at DEPTH.
  - When full, the read pointer advances with the write, so the oldest entry is overwritten, and overflow is set (sticky until arm or reset).
  - cycle_count increments per capture and saturates at all-ones.
  - When the capture that makes cycle_count equal the latched limit completes -> DONE.
- DONE: halt=1. rd_valid=1 while entry count >0. rd_data is the combinational read of the oldest entry. On rd_valid&&rd_ready, the read pointer increments modulo DEPTH and the count decrements. When empty, the block stays in DONE with halt still high.
- Entries are never popped outside DONE; rd_valid=0 in IDLE, ARMED and CAPTURE.
- arm in any state, including mid-CAPTURE or mid-drain:
  - clears pointers, count, cycle_count and overflow;
  - latches stop_limit and trig_pc;
  - state -> ARMED next edge;
  - arm takes priority over a simultaneous capture or pop.
- Reset mid-run discards everything; it is asynchronous, so outputs fall to reset values without waiting for a clock edge.
- Latency: an input sampled at edge N is readable from edge N+1 onward, once in DONE.

Optional Feature:
- Macro TRACE_TRIGGER_EN.
- Defined: ARMED waits for pc_q==trig_pc, with no timeout. trig_pc is latched on arm.
- Undefined: trig_pc is ignored (port still present), and ARMED always advances after one cycle.

Decomposition:
- Package trace_pkg holds:
  - the state enum trace_state_t (IDLE, ARMED, CAPTURE, DONE);
  - the packed struct trace_entry_t {pc_q, pc_d, instruction, reg_write_en}, parametrised by DATA_W via package localparam;
  - the default constants.
- Sub-module trace_ring: DEPTH×entry storage with write/read pointers, count, full/empty and overwrite-on-full. The parent holds the FSM, counters and flags.

Test Plan:
- Reset with DEPTH=8, stop_limit=6, no trigger: arm at cycle 2, PC steps 0x0,0x4,...
  -> state goes 1 then 2. halt rises after the 6th capture, with cycle_count=6, overflow=0. Draining returns pc_q 0x0..0x14 in order, then rd_valid=0.
- DEPTH=4, stop_limit=6 -> overflow=1. Drain yields exactly 4 entries with pc_q 0x8,0xC,0x10,0x14.
- TRACE_TRIGGER_EN, trig_pc=0x10, stop_limit=2 -> ARMED holds through PCs 0x0–0xC. The captured pc_q values are 0x10 and 0x14, and halt=1.
- Backpressure: in DONE, hold rd_ready=0 for 5 cycles -> rd_data is stable at the first entry and the count is unchanged. Pulse rd_ready for one cycle -> the second entry appears next cycle.
- arm asserted mid-CAPTURE at cycle_count=3 -> cycle_count=0, count=0, overflow=0 next edge and state=ARMED. The new run completes normally.
- Assert reset asynchronously between edges during DONE -> halt, rd_valid and cycle_count clear immediately, with state=IDLE.
